// File: rtl/uart_rx_sampler.sv
// UART receive bit recovery: start validation, 2-of-3 centre vote, stop check, valid/ready delivery.
// Optional parity stage and ParityOdd_i port enabled by defining UART_RX_PARITY_EN.
module uart_rx_sampler #(
  parameter int         DATA_BITS = 8,
  parameter logic [4:0] MIN_ACQ   = 5'd4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxEn_i,
  input  logic                 AcqSig_i,
  input  logic [4:0]           AcqPerBit_i,
  input  logic                 Rx_i,
`ifdef UART_RX_PARITY_EN
  input  logic                 ParityOdd_i,
`endif
  output logic [DATA_BITS-1:0] RxData_o,
  output logic                 RxValid_o,
  input  logic                 RxReady_i,
  output logic                 FrameErr_o,
  output logic                 ParityErr_o,
  output logic                 OverrunErr_o,
  output logic                 Busy_o
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_next;
  logic                 rx_m, rx_s;
  logic [4:0]           n_r, s, m;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 v0, v1, maj;
  logic                 at_lo, at_mid, at_hi, at_end, last_bit;
  logic                 start_frame, deliver, active_tick, accept, perr_new;

  // Two-flop synchronizer, idle-high reset so a reset never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx_i;
      rx_s <= rx_m;
    end
  end

  assign m        = n_r >> 1;
  assign at_lo    = (s == 5'(m - 5'd1));
  assign at_mid   = (s == m);
  assign at_hi    = (s == 5'(m + 5'd1));
  assign at_end   = (s == 5'(n_r - 5'd1));
  assign last_bit = (bit_cnt == CW'(DATA_BITS - 1));
  assign maj      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    deliver     = 1'b0;
    if (!RxEn_i) begin
      state_next = IDLE;
    end else if (AcqSig_i) begin
      case (state)
        IDLE:
          if (!rx_s) begin
            state_next  = START;
            start_frame = 1'b1;
          end
        START:
          if (at_hi && maj) state_next = IDLE;
          else if (at_end)  state_next = DATA;
        DATA:
          if (at_end && last_bit) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (at_end) state_next = STOP;
`endif
        // Release on the stop-bit centre so the next start edge is caught early
        STOP:
          if (at_hi) begin
            state_next = IDLE;
            deliver    = 1'b1;
          end
        default: state_next = IDLE;
      endcase
    end
  end

  assign active_tick = RxEn_i && AcqSig_i && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r     <= MIN_ACQ;
      s       <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      v0      <= 1'b1;
      v1      <= 1'b1;
    end else if (start_frame) begin
      n_r     <= (AcqPerBit_i < MIN_ACQ) ? MIN_ACQ : AcqPerBit_i;
      s       <= 5'd1;
      bit_cnt <= '0;
    end else if (active_tick) begin
      s <= at_end ? 5'd0 : 5'(s + 5'd1);
      if (at_lo)  v0 <= rx_s;
      if (at_mid) v1 <= rx_s;
      if (state == DATA) begin
        if (at_hi)  shift   <= {maj, shift[DATA_BITS-1:1]};
        if (at_end) bit_cnt <= CW'(bit_cnt + 1'b1);
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       par_bit <= 1'b0;
    else if (active_tick && state == PARITY && at_hi) par_bit <= maj;
  end
  assign perr_new = par_bit ^ (^shift) ^ ParityOdd_i;
`else
  assign perr_new = 1'b0;
`endif

  assign accept = RxValid_o & RxReady_i;

  // A same-cycle handshake frees the register for this cycle's delivery
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RxData_o     <= '0;
      RxValid_o    <= 1'b0;
      FrameErr_o   <= 1'b0;
      ParityErr_o  <= 1'b0;
      OverrunErr_o <= 1'b0;
      Busy_o       <= 1'b0;
    end else begin
      OverrunErr_o <= 1'b0;
      Busy_o       <= (state_next != IDLE);
      if (deliver) begin
        if (!RxValid_o || accept) begin
          RxData_o    <= shift;
          FrameErr_o  <= ~maj;
          ParityErr_o <= perr_new;
          RxValid_o   <= 1'b1;
        end else begin
          OverrunErr_o <= 1'b1;
        end
      end else if (accept) begin
        RxValid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Receive-side bit recovery stage that sits directly downstream of the baudrate generator. Consumes its one-clock acquisition strobe, oversamples the serial line, detects and validates start bits, recovers 8 data bits LSB first by centre majority vote, checks the stop bit, and presents each byte on a valid/ready handshake to the receive buffer. Reports framing, parity and overrun errors alongside the data.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `MIN_ACQ`, 5'd4: lower clamp on acquisition samples per bit.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `RxEn_i`  in  1  receiver enable; low forces FSM to IDLE.
- `AcqSig_i`  in  1  one-clock acquisition strobe from the baudrate generator.
- `AcqPerBit_i`  in  5  acquisition strobes per bit (up-count + down-count nibbles summed upstream).
- `Rx_i`  in  1  asynchronous serial line, idle high.
- `ParityOdd_i`  in  1  1 = odd parity, 0 = even; present only with `UART_RX_PARITY_EN`.
- `RxData_o`  out  8  received byte.
- `RxValid_o`  out  1  byte available; held until accepted.
- `RxReady_i`  in  1  consumer accepts byte when `RxValid_o & RxReady_i`.
- `FrameErr_o`  out  1  stop bit sampled 0; travels with `RxData_o`.
- `ParityErr_o`  out  1  parity mismatch; travels with `RxData_o`; tied 0 without macro.
- `OverrunErr_o`  out  1  one-clock pulse: completed byte dropped.
- `Busy_o`  out  1  FSM not in IDLE.

## Operation
- `Rx_i` passes a 2-flop synchronizer (reset value 1); all decisions use the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP. Only `AcqSig_i` strobes advance sampling.
- IDLE: on strobe with `rx_s==0` and `RxEn_i==1` -> START; this strobe is sample index 0. `AcqPerBit_i` latched to `n_r` here; if below `MIN_ACQ`, `n_r = MIN_ACQ`.
- Sample counter `s` (5 bits) counts 0..n_r-1 per bit, wraps to 0 and advances bit on index n_r-1.
- Centre m = n_r>>1. Bit value = majority of samples at indices m-1, m, m+1 (2-of-3).
- START: majority computed at index m+1; if 1 -> glitch, return to IDLE, no output. Else continue; at index n_r-1 -> DATA.
- DATA: shift majority into bit `DATA_BITS-1` of shift reg, shift right (LSB first). After `DATA_BITS` bits -> PARITY (macro) else STOP.
- PARITY: expected = XOR(data) ^ `ParityOdd_i`; mismatch flags parity error.
- STOP: at index m+1 decide stop; deliver byte; return to IDLE immediately (half-bit early release for resync to next start edge).
- Delivery: if `RxValid_o==0` or (`RxValid_o & RxReady_i`) same cycle -> load `RxData_o`, `FrameErr_o` (stop==0), `ParityErr_o`, set `RxValid_o`. Else new byte dropped, old byte/flags kept, `OverrunErr_o` pulses.
- `RxEn_i` low: FSM -> IDLE next clock, partial frame discarded; output register and `RxValid_o` unaffected.
- `AcqPerBit_i` changes mid-frame are ignored until next start.

## Timing
- Reset values: `RxData_o`=0, `RxValid_o`=0, `FrameErr_o`=0, `ParityErr_o`=0, `OverrunErr_o`=0, `Busy_o`=0; FSM IDLE, `rx_s`=1.
- Line-to-sample latency: 2 clocks synchronizer.
- `RxValid_o` rises the clock after the strobe at stop-bit index m+1; `RxValid_o` falls the clock after a handshake with no new delivery that cycle.
- `Busy_o` registered: high the clock after start strobe, low the clock after stop decision or glitch abort.
- Strobe and handshake in same clock: both take effect; acceptance frees the register for that cycle's delivery.
- Reset mid-frame: all state cleared asynchronously; no partial byte emitted.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state and `ParityOdd_i` port present; frame = start + 8 data + parity + stop.
- Undefined: no PARITY state, no `ParityOdd_i` port, `ParityErr_o` tied 0; frame = start + 8 data + stop.

## Test plan
- `AcqPerBit_i`=8, frame 0x55, valid stop -> `RxData_o`=0x55, `RxValid_o` high one clock after stop index 5 strobe, errors 0.
- Low glitch of 2 strobes on idle line, n=8 -> START entered, aborted at index 5, `RxValid_o` stays 0, `Busy_o` returns 0.
- Frame 0xA3 with stop bit 0 -> `RxData_o`=0xA3, `FrameErr_o`=1.
- Macro on, `ParityOdd_i`=1, 0x0F with parity bit 0 -> `ParityErr_o`=1; parity bit 1 -> 0.
- Two back-to-back bytes 0x11, 0x22 with `RxReady_i`=0 -> `RxData_o` stays 0x11, `OverrunErr_o` one-clock pulse at second stop decision.
- `AcqPerBit_i`=2 -> clamped to 4, 0x3C received correctly; `RxEn_i` dropped mid-DATA -> IDLE next clock, no byte.
